// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor: state encoding and the
// timeout derivation used by the period counter.
package pll_mon_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_SYNC_ENC    = 2'd1;
  localparam logic [1:0] ST_MEASURE_ENC = 2'd2;
  localparam logic [1:0] ST_LOCKED_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    SYNC    = ST_SYNC_ENC,
    MEASURE = ST_MEASURE_ENC,
    LOCKED  = ST_LOCKED_ENC
  } pll_state_e;

  // First count value that can never be an in-tolerance period.
  function automatic int unsigned pll_timeout(input int unsigned period_nom,
                                              input int unsigned tol);
    return period_nom + tol + 1;
  endfunction

endpackage

// File: rtl/pll_mon_edge_sync.sv
// Brings the monitored clock into the clk domain through two flops and
// flags its rising edge using one further delay flop.
module pll_mon_edge_sync
  import pll_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rise_c = sync & ~dly;

endmodule

// File: rtl/pll_lock_monitor.sv
// Measures the period of an asynchronous monitored clock in clk cycles and
// reports lock / error status. Define PLL_LOCK_MONITOR_HIST_EN for min/max history.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned PERIOD_NOM = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             err_clr,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err,
  output logic [CNT_W-1:0] per_min,
  output logic [CNT_W-1:0] per_max
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(pll_timeout(PERIOD_NOM, TOL));
  localparam logic [CNT_W-1:0] GOOD_LO  = CNT_W'(PERIOD_NOM - TOL);
  localparam logic [CNT_W-1:0] GOOD_HI  = CNT_W'(PERIOD_NOM + TOL);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

  pll_state_e       state_q;
  pll_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_inc;
  logic             locked_d;
  logic [CNT_W-1:0] period_d;
  logic             vld_d;
  logic             err_set;
  logic             err_d;
  logic             rise_c;
  logic             good_c;

  pll_mon_edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mon_clk),
    .rise_c   (rise_c)
  );

  assign good_c  = (cnt_q >= GOOD_LO) && (cnt_q <= GOOD_HI);
  assign run_inc = run_q + RUN_W'(1);

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    locked_d = locked;
    period_d = period;
    vld_d    = 1'b0;
    err_set  = 1'b0;

    if (rise_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        run_d    = '0;
        locked_d = 1'b0;
        if (enable) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        run_d    = '0;
        locked_d = 1'b0;
        if (rise_c) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (good_c) begin
            run_d = run_inc;
            if (run_inc == RUN_LOCK) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            err_set = 1'b1;
            run_d   = '0;
          end
        end else if (cnt_q == TIMEOUT) begin
          err_set  = 1'b1;
          locked_d = 1'b0;
          run_d    = '0;
          state_d  = SYNC;
        end
      end
      LOCKED: begin
        if (rise_c) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!good_c) begin
            err_set  = 1'b1;
            locked_d = 1'b0;
            run_d    = '0;
            state_d  = MEASURE;
          end
        end else if (cnt_q == TIMEOUT) begin
          err_set  = 1'b1;
          locked_d = 1'b0;
          run_d    = '0;
          state_d  = SYNC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disabling overrides everything; err and period keep their values.
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      run_d    = '0;
      locked_d = 1'b0;
      period_d = period;
      vld_d    = 1'b0;
      err_set  = 1'b0;
    end
  end

  // A new error beats a simultaneous clear.
  assign err_d = err_set | (err & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      run_q      <= '0;
      locked     <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      locked     <= locked_d;
      period     <= period_d;
      period_vld <= vld_d;
      err        <= err_d;
    end
  end

`ifdef PLL_LOCK_MONITOR_HIST_EN
  // Running min/max of reported periods; err_clr restarts the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_min <= '1;
      per_max <= '0;
    end else if (err_clr) begin
      per_min <= '1;
      per_max <= '0;
    end else if (vld_d) begin
      if (period_d < per_min) begin
        per_min <= period_d;
      end
      if (period_d > per_max) begin
        per_max <= period_d;
      end
    end
  end
`else
  assign per_min = '0;
  assign per_max = '0;
`endif

endmodule
